lfsr_arbiter: RTL and testbench

- Sequences and shares one lfsr instance (N-bit, ports clk/reset/load_seed/seed_data/lfsr_data/lfsr_done) between NUM_REQ requesters.
- Seeds the lfsr after reset and on software seed requests, and replaces an illegal zero seed.
- Detects lock-up at zero and reseeds.
- Grants one requester per cycle in round-robin order and returns the current lfsr_data as a random word.

---
 rtl/lfsr_pkg.sv | 24 ++
 rtl/rr_arbiter.sv | 40 ++++
 rtl/lfsr_arbiter.sv | 167 ++++++++++++++++
 tb/tb_lfsr_arbiter.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lfsr_pkg.sv
// lfsr_pkg: shared types and helpers for the lfsr arbiter slice.
//   state_e     - sequencing states of lfsr_arbiter
//   lfsr_period - number of distinct non-zero states of an n-bit maximal lfsr
//   rr_index    - wrap-around candidate index for the round-robin search
package lfsr_pkg;

  typedef enum logic [1:0] {
    ST_INIT,
    ST_LOAD,
    ST_SETTLE,
    ST_SERVE
  } state_e;

  function automatic int unsigned lfsr_period(input int unsigned n);
    return (32'd1 << n) - 32'd1;
  endfunction

  function automatic int unsigned rr_index(input int unsigned ptr,
                                           input int unsigned k,
                                           input int unsigned n);
    return (ptr + k) % n;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick.
//   req_i   - eligible requesters
//   ptr_i   - index of the last winner; search starts at ptr_i+1
//   gnt_o   - one-hot winner (zero when nothing is eligible)
//   idx_o   - binary index of the winner
//   valid_o - a winner exists
module rr_arbiter
  import lfsr_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [PTR_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [PTR_W-1:0]   idx_o,
  output logic               valid_o
);

  logic [PTR_W-1:0] cand;

  // Walk the candidates from farthest to nearest so the last hit, which is
  // the one closest after the pointer, is the one that sticks.
  always_comb begin
    gnt_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    cand    = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = PTR_W'(rr_index(32'(ptr_i), k, NUM_REQ));
      if (req_i[cand]) begin
        gnt_o       = '0;
        gnt_o[cand] = 1'b1;
        idx_o       = cand;
        valid_o     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/lfsr_arbiter.sv
// lfsr_arbiter: seeds and sequences an external lfsr and shares its output
// between NUM_REQ requesters in round-robin order.
//   clk, reset            - clock and async active-high reset
//   seed_req/seed_in      - software reseed request (zero seed replaced)
//   seed_ack              - pulse in the LOAD cycle that follows an accepted seed_req
//   req/gnt               - level requests, registered one-hot grant pulse
//   rnd_data/rnd_valid    - lfsr word captured at the grant edge
//   lfsr_load_seed/_data  - drive the external lfsr seed port
//   lfsr_data             - current lfsr output
//   lock_err              - pulse after an all-zero lfsr word was seen while serving
//   wrap/steps            - serve-cycle counter since last seed, wraps at 2^N-1
//
// state  | meaning
// INIT   | after reset, nothing loaded yet
// LOAD   | lfsr_load_seed high with the pending seed
// SETTLE | lfsr holds the seed, no grants
// SERVE  | arbitrate requests, watch for reseed and lock-up
module lfsr_arbiter
  import lfsr_pkg::*;
#(
  parameter int             N            = 4,
  parameter int             NUM_REQ      = 2,
  parameter logic [N-1:0]   SEED_DEFAULT = {N{1'b1}}
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               seed_req,
  input  logic [N-1:0]       seed_in,
  output logic               seed_ack,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic [N-1:0]       rnd_data,
  output logic               rnd_valid,
  output logic               lfsr_load_seed,
  output logic [N-1:0]       lfsr_seed_data,
  input  logic [N-1:0]       lfsr_data,
  output logic               lock_err,
  output logic               wrap,
  output logic [N-1:0]       steps
);

  localparam int           PTR_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [N-1:0] STEP_LAST = N'(lfsr_period(N) - 1);

  state_e             state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [N-1:0]       rnd_data_q, rnd_data_d;
  logic               rnd_valid_q, rnd_valid_d;
  logic               seed_ack_q, seed_ack_d;
  logic               lock_err_q, lock_err_d;
  logic               wrap_q, wrap_d;
  logic [N-1:0]       steps_q, steps_d;
  logic               load_q, load_d;
  logic [N-1:0]       seed_q, seed_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;

  logic [NUM_REQ-1:0] pick_gnt;
  logic [PTR_W-1:0]   pick_idx;
  logic               pick_valid;

  // A requester that holds gnt this cycle is still asserting req; masking it
  // keeps one request from being served twice.
  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_rr (
    .req_i   (req & ~gnt_q),
    .ptr_i   (ptr_q),
    .gnt_o   (pick_gnt),
    .idx_o   (pick_idx),
    .valid_o (pick_valid)
  );

  always_comb begin
    state_d     = state_q;
    gnt_d       = '0;
    rnd_data_d  = rnd_data_q;
    rnd_valid_d = 1'b0;
    seed_ack_d  = 1'b0;
    lock_err_d  = 1'b0;
    wrap_d      = 1'b0;
    steps_d     = steps_q;
    load_d      = 1'b0;
    seed_d      = seed_q;
    ptr_d       = ptr_q;
    case (state_q)
      ST_INIT: begin
        state_d = ST_LOAD;
        load_d  = 1'b1;
        steps_d = '0;
      end
      ST_LOAD: begin
        state_d = ST_SETTLE;
        steps_d = '0;
      end
      ST_SETTLE: begin
        state_d = ST_SERVE;
        steps_d = '0;
      end
      ST_SERVE: begin
        if (steps_q == STEP_LAST) begin
          steps_d = '0;
          wrap_d  = 1'b1;
        end else begin
          steps_d = steps_q + N'(1);
        end
        if (seed_req) begin
          seed_d     = (seed_in == '0) ? SEED_DEFAULT : seed_in;
          seed_ack_d = 1'b1;
          load_d     = 1'b1;
          state_d    = ST_LOAD;
        end else if (lfsr_data == '0) begin
          seed_d     = SEED_DEFAULT;
          lock_err_d = 1'b1;
          load_d     = 1'b1;
          state_d    = ST_LOAD;
        end else if (pick_valid) begin
          gnt_d       = pick_gnt;
          rnd_valid_d = 1'b1;
          rnd_data_d  = lfsr_data;
          ptr_d       = pick_idx;
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_INIT;
      gnt_q       <= '0;
      rnd_data_q  <= '0;
      rnd_valid_q <= 1'b0;
      seed_ack_q  <= 1'b0;
      lock_err_q  <= 1'b0;
      wrap_q      <= 1'b0;
      steps_q     <= '0;
      load_q      <= 1'b0;
      seed_q      <= SEED_DEFAULT;
      ptr_q       <= '0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      rnd_data_q  <= rnd_data_d;
      rnd_valid_q <= rnd_valid_d;
      seed_ack_q  <= seed_ack_d;
      lock_err_q  <= lock_err_d;
      wrap_q      <= wrap_d;
      steps_q     <= steps_d;
      load_q      <= load_d;
      seed_q      <= seed_d;
      ptr_q       <= ptr_d;
    end
  end

  assign gnt            = gnt_q;
  assign rnd_data       = rnd_data_q;
  assign rnd_valid      = rnd_valid_q;
  assign seed_ack       = seed_ack_q;
  assign lock_err       = lock_err_q;
  assign wrap           = wrap_q;
  assign steps          = steps_q;
  assign lfsr_load_seed = load_q;
  // The pending seed is always visible; the lfsr only takes it while LOAD holds load_seed.
  assign lfsr_seed_data = seed_q;

endmodule

// File: tb/tb_lfsr_arbiter.sv
module tb_lfsr_arbiter;

  localparam int           N  = 4;
  localparam int           NR = 2;
  localparam int           PW = 1;
  localparam logic [N-1:0] SD = 4'hF;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          seed_req = 1'b0;
  logic [N-1:0]  seed_in = '0;
  logic [NR-1:0] req = '0;
  logic          force_zero = 1'b0;

  logic          seed_ack, rnd_valid, lfsr_load_seed, lock_err, wrap;
  logic [NR-1:0] gnt;
  logic [N-1:0]  rnd_data, lfsr_seed_data, lfsr_data, steps;
  logic [N-1:0]  lfsr_q;

  int n_cmp = 0;
  int n_fail = 0;

  lfsr_arbiter #(.N(N), .NUM_REQ(NR), .SEED_DEFAULT(SD)) dut (
    .clk            (clk),
    .reset          (reset),
    .seed_req       (seed_req),
    .seed_in        (seed_in),
    .seed_ack       (seed_ack),
    .req            (req),
    .gnt            (gnt),
    .rnd_data       (rnd_data),
    .rnd_valid      (rnd_valid),
    .lfsr_load_seed (lfsr_load_seed),
    .lfsr_seed_data (lfsr_seed_data),
    .lfsr_data      (lfsr_data),
    .lock_err       (lock_err),
    .wrap           (wrap),
    .steps          (steps)
  );

  always #5 clk = ~clk;

  // Stand-in for the external lfsr: x^4+x^3+1, loads when load_seed is high.
  function automatic logic [N-1:0] lfsr_step(input logic [N-1:0] s);
    return {s[2:0], s[3] ^ s[2]};
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) lfsr_q <= SD;
    else if (lfsr_load_seed) lfsr_q <= lfsr_seed_data;
    else lfsr_q <= lfsr_step(lfsr_q);
  end

  assign lfsr_data = force_zero ? '0 : lfsr_q;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: m_wait counts the cycles left before serving
  // (3 after reset: init/load/settle, 2 after a reseed: load/settle).
  int            m_wait = 3;
  int            m_steps = 0;
  int            m_last = 0;
  logic [N-1:0]  m_seed = SD;
  logic [NR-1:0] e_gnt = '0;
  logic [N-1:0]  e_rnd = '0;
  logic          e_valid = 1'b0, e_ack = 1'b0, e_lock = 1'b0, e_wrap = 1'b0, e_load = 1'b0;

  initial begin : model
    logic [NR-1:0] prev, elig;
    logic [PW-1:0] idx;
    bit            found;
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        m_wait = 3; m_steps = 0; m_last = 0; m_seed = SD;
        e_gnt = '0; e_rnd = '0; e_valid = 0; e_ack = 0; e_lock = 0; e_wrap = 0; e_load = 0;
      end else begin
        prev = e_gnt;
        e_gnt = '0; e_valid = 0; e_ack = 0; e_lock = 0; e_wrap = 0;
        if (m_wait == 0) begin
          m_steps = (m_steps + 1) % 15;
          e_wrap  = (m_steps == 0);
          if (seed_req) begin
            m_seed = (seed_in == 0) ? SD : seed_in;
            e_ack  = 1; m_wait = 2;
          end else if (lfsr_data == 0) begin
            m_seed = SD;
            e_lock = 1; m_wait = 2;
          end else begin
            elig  = req & ~prev;
            found = 0;
            for (int i = 1; i <= NR; i++) begin
              idx = PW'((m_last + i) % NR);
              if (!found && elig[idx]) begin
                found   = 1;
                e_gnt   = NR'(1) << idx;
                e_valid = 1;
                e_rnd   = lfsr_data;
                m_last  = int'(idx);
              end
            end
          end
        end else begin
          m_wait--;
          m_steps = 0;
        end
        e_load = (m_wait == 2);
      end
    end
  end

  initial begin : compare
    forever begin
      @(negedge clk);
      chk("gnt", 32'(gnt), 32'(e_gnt));
      chk("rnd_valid", 32'(rnd_valid), 32'(e_valid));
      chk("rnd_data", 32'(rnd_data), 32'(e_rnd));
      chk("seed_ack", 32'(seed_ack), 32'(e_ack));
      chk("lock_err", 32'(lock_err), 32'(e_lock));
      chk("wrap", 32'(wrap), 32'(e_wrap));
      chk("steps", 32'(steps), 32'(m_steps));
      chk("load_seed", 32'(lfsr_load_seed), 32'(e_load));
      chk("seed_data", 32'(lfsr_seed_data), 32'(m_seed));
    end
  end

  initial begin : watchdog
    #200000;
    n_fail++;
    $display("FAIL watchdog: time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

  initial begin : stim
    int grants, consec, wraps;
    logic [NR-1:0] prevg;
    #1 reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_valid", 32'(rnd_valid), 0);
    chk("rst_load", 32'(lfsr_load_seed), 0);
    chk("rst_seed", 32'(lfsr_seed_data), 'hF);
    reset = 1'b0;                                 // cycle 1: INIT
    @(negedge clk);                               // cycle 2: LOAD
    chk("c2_load", 32'(lfsr_load_seed), 1);
    chk("c2_seed", 32'(lfsr_seed_data), 'hF);
    @(negedge clk);                               // cycle 3: SETTLE
    chk("c3_load", 32'(lfsr_load_seed), 0);
    @(negedge clk);                               // cycle 4: SERVE
    chk("c4_steps", 32'(steps), 0);
    chk("c4_gnt", 32'(gnt), 0);

    // Both requesters held: alternating grants starting with requester 1.
    req = 2'b11;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("rr_seq", 32'(gnt), (i % 2 == 0) ? 2 : 1);
      chk("rr_valid", 32'(rnd_valid), 1);
      if (i == 0) chk("rnd_first", 32'(rnd_data), 'hE);
      if (i == 1) chk("rnd_second", 32'(rnd_data), 'hC);
    end

    // Single held request: granted every other cycle only.
    req = 2'b00;
    @(negedge clk);
    req = 2'b01;
    grants = 0; consec = 0; prevg = '0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (gnt == 2'b01) grants++;
      if (gnt != 0 && prevg != 0) consec++;
      prevg = gnt;
    end
    chk("single_grants", 32'(grants), 4);
    chk("no_consec", 32'(consec), 0);

    // Zero seed request is replaced by the default seed.
    req = 2'b11; seed_in = 4'b0000; seed_req = 1'b1;
    @(negedge clk);
    chk("zs_ack", 32'(seed_ack), 1);
    chk("zs_gnt", 32'(gnt), 0);
    chk("zs_load", 32'(lfsr_load_seed), 1);
    chk("zs_seed", 32'(lfsr_seed_data), 'hF);
    seed_req = 1'b0;
    @(negedge clk);
    chk("zs_settle_gnt", 32'(gnt), 0);
    @(negedge clk);
    chk("zs_serve1_gnt", 32'(gnt), 0);
    @(negedge clk);
    chk("zs_resume", 32'(gnt != 0), 1);

    // Non-zero seed request passes straight through.
    seed_in = 4'b0101; seed_req = 1'b1;
    @(negedge clk);
    chk("s5_ack", 32'(seed_ack), 1);
    chk("s5_seed", 32'(lfsr_seed_data), 5);
    seed_req = 1'b0;
    @(negedge clk);
    @(negedge clk);

    // Lock-up: force the lfsr word to zero for one serve cycle.
    force_zero = 1'b1;
    @(negedge clk);
    chk("lk_err", 32'(lock_err), 1);
    chk("lk_valid", 32'(rnd_valid), 0);
    chk("lk_load", 32'(lfsr_load_seed), 1);
    chk("lk_seed", 32'(lfsr_seed_data), 'hF);
    force_zero = 1'b0;
    @(negedge clk);
    chk("lk_pulse", 32'(lock_err), 0);
    @(negedge clk);

    // Free run after seeding: wrap in serve cycle 16 only, steps back to 0.
    req = 2'b00; seed_in = 4'b1001; seed_req = 1'b1;
    @(negedge clk);
    chk("wr_ack", 32'(seed_ack), 1);
    seed_req = 1'b0;
    @(negedge clk);
    wraps = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (wrap) begin
        wraps++;
        chk("wrap_pos", 32'(i), 15);
        chk("wrap_steps", 32'(steps), 0);
      end
    end
    chk("wrap_once", 32'(wraps), 1);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      req        = NR'($urandom);
      seed_req   = ($urandom_range(0, 19) == 0);
      seed_in    = ($urandom_range(0, 3) == 0) ? '0 : N'($urandom);
      force_zero = ($urandom_range(0, 29) == 0);
    end
    @(negedge clk);
    seed_req = 1'b0; force_zero = 1'b0; req = 2'b11;

    // Reset in the middle of a grant.
    for (int k = 0; k < 12 && gnt == 0; k++) @(negedge clk);
    chk("pre_rst_gnt", 32'(gnt != 0), 1);
    #2 reset = 1'b1;
    #1;
    chk("async_gnt", 32'(gnt), 0);
    chk("async_valid", 32'(rnd_valid), 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rerun_load", 32'(lfsr_load_seed), 1);
    repeat (10) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
